// File: rtl/bp_reset_seq_pkg.sv
// Shared types and sizing helpers for the board reset sequencer.
// State encoding is exported on state_o, so values are fixed here.
package bp_reset_seq_pkg;

    typedef enum logic [2:0] {
        e_init  = 3'd0,
        e_pulse = 3'd1,
        e_hold  = 3'd2,
        e_wait  = 3'd3,
        e_run   = 3'd4,
        e_error = 3'd5
    } bp_reset_seq_state_e;

    function automatic int unsigned cnt_width_f(input int unsigned pulse,
                                                input int unsigned hold,
                                                input int unsigned stagger,
                                                input int unsigned timeout);
        int unsigned m;
        m = pulse;
        if (hold > m) m = hold;
        if (stagger > m) m = stagger;
        if (timeout > m) m = timeout;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/bp_async_sync_chain.sv
// Multi-bit flop chain bringing asynchronous level signals into clk_i.
// Each bit is an independent level; no cross-bit coherency is implied.
module bp_async_sync_chain #(
    parameter int unsigned width_p       = 3,
    parameter int unsigned sync_stages_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] d_i,
    output logic [width_p-1:0] q_o
);

    logic [width_p-1:0] stage_q [sync_stages_p];
    logic [width_p-1:0] stage_d [sync_stages_p];

    always_comb begin
        stage_d[0] = d_i;
        for (int unsigned i = 1; i < sync_stages_p; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned i = 0; i < sync_stages_p; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q[sync_stages_p-1];

endmodule

// File: rtl/bp_reset_sequencer.sv
// Board reset sequencer: PLL reset pulse, global hold, then staggered
// per-domain release gated by each domain's synchronized ready.
module bp_reset_sequencer
    import bp_reset_seq_pkg::*;
#(
    parameter int unsigned num_domains_p    = 3,
    parameter int unsigned sync_stages_p    = 2,
    parameter int unsigned pulse_cycles_p   = 4,
    parameter int unsigned hold_cycles_p    = 16,
    parameter int unsigned stagger_cycles_p = 8,
    parameter int unsigned timeout_cycles_p = 1024
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     soft_reset_i,
    input  logic [num_domains_p-1:0] ready_i,
    output logic                     pll_reset_o,
    output logic [num_domains_p-1:0] reset_o,
    output logic                     done_o,
    output logic                     error_o,
    output logic [2:0]               state_o,
    output logic [(num_domains_p > 1 ? $clog2(num_domains_p) : 1)-1:0] domain_idx_o
);

    localparam int unsigned CntW = cnt_width_f(pulse_cycles_p, hold_cycles_p,
                                               stagger_cycles_p, timeout_cycles_p);
    localparam int unsigned IdxW = (num_domains_p > 1) ? $clog2(num_domains_p) : 1;
    // Timeout fires on the edge where the counter would reach timeout-1.
    localparam int unsigned TimeoutFireInt = (timeout_cycles_p >= 2) ? timeout_cycles_p - 2 : 0;

    localparam logic [CntW-1:0] PulseLast   = CntW'(pulse_cycles_p - 1);
    localparam logic [CntW-1:0] HoldLast    = CntW'(hold_cycles_p - 1);
    localparam logic [CntW-1:0] StaggerLast = CntW'(stagger_cycles_p - 1);
    localparam logic [CntW-1:0] TimeoutFire = CntW'(TimeoutFireInt);
    localparam logic [IdxW-1:0] LastIdx     = IdxW'(num_domains_p - 1);

    bp_reset_seq_state_e      state_q, state_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [IdxW-1:0]          idx_q, idx_d;
    logic                     pll_q, pll_d;
    logic [num_domains_p-1:0] rst_q, rst_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    logic [num_domains_p-1:0] ready_sync;
    logic                     release_now;
    logic                     timeout_now;
    logic                     soft_now;

    bp_async_sync_chain #(
        .width_p      (num_domains_p),
        .sync_stages_p(sync_stages_p)
    ) u_ready_sync (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .d_i      (ready_i),
        .q_o      (ready_sync)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_init;
            cnt_q   <= '0;
            idx_q   <= '0;
            pll_q   <= 1'b0;
            rst_q   <= '1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pll_q   <= pll_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        release_now = 1'b0;
        timeout_now = 1'b0;
        soft_now    = soft_reset_i && (state_q != e_init);
        unique case (state_q)
            e_init:  state_d = e_pulse;
            e_pulse: if (cnt_q == PulseLast) state_d = e_hold;
            e_hold:  if (cnt_q == HoldLast) state_d = e_wait;
            e_wait: begin
                if ((cnt_q >= StaggerLast) && ready_sync[idx_q]) begin
                    release_now = 1'b1;
                    if (idx_q == LastIdx) state_d = e_run;
                end else if ((timeout_cycles_p != 0) && (cnt_q >= TimeoutFire)) begin
                    timeout_now = 1'b1;
                    state_d     = e_error;
                end
            end
            e_run, e_error: state_d = state_q;
            default: state_d = e_init;
        endcase
        if (soft_now) state_d = e_pulse;
    end

    always_comb begin
        cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        idx_d  = idx_q;
        rst_d  = rst_q;
        done_d = done_q;
        err_d  = err_q;
        pll_d  = (state_d == e_pulse);
        if (state_d != state_q) cnt_d = '0;
        if (state_q == e_hold && state_d == e_wait) idx_d = '0;
        if (release_now) begin
            cnt_d        = '0;
            rst_d[idx_q] = 1'b0;
            if (idx_q != LastIdx) idx_d = idx_q + 1'b1;
            if (idx_q == LastIdx) done_d = 1'b1;
        end
        if (timeout_now) err_d = 1'b1;
        // Soft restart overrides any same-cycle release or timeout.
        if (soft_now) begin
            cnt_d  = '0;
            idx_d  = '0;
            rst_d  = '1;
            done_d = 1'b0;
            err_d  = 1'b0;
        end
    end

    assign pll_reset_o  = pll_q;
    assign reset_o      = rst_q;
    assign done_o       = done_q;
    assign error_o      = err_q;
    assign state_o      = state_q;
    assign domain_idx_o = idx_q;

endmodule

// File: tb/tb_bp_reset_sequencer.sv
// Bench for bp_reset_sequencer: timestamp-based model checked every cycle,
// plus directed literal checks at hand-computed edges.
module tb_bp_reset_sequencer;
    import bp_reset_seq_pkg::*;

    localparam int N = 3;
    localparam int P = 4;
    localparam int H = 16;
    localparam int S = 8;
    localparam int T = 1024;

    logic       clk_i        = 1'b0;
    logic       reset_n_i    = 1'b0;
    logic       soft_reset_i = 1'b0;
    logic [2:0] ready_i      = 3'b000;
    logic       pll_reset_o;
    logic [2:0] reset_o;
    logic       done_o;
    logic       error_o;
    logic [2:0] state_o;
    logic [1:0] domain_idx_o;

    bp_reset_sequencer dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .soft_reset_i(soft_reset_i),
        .ready_i     (ready_i),
        .pll_reset_o (pll_reset_o),
        .reset_o     (reset_o),
        .done_o      (done_o),
        .error_o     (error_o),
        .state_o     (state_o),
        .domain_idx_o(domain_idx_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;

    // Model: g is the index of the last rising edge since reset release (edge 0).
    int         g       = -1;
    bit         m_init  = 1'b1;
    int         start   = 0;
    int         wstart  = 0;
    int         hist_lo = 0;
    int         m_idx   = 0;
    logic [2:0] m_rst   = 3'b111;
    bit         m_done  = 1'b0;
    bit         m_err   = 1'b0;
    logic [2:0] hist [0:4095];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, g, act, exp);
        end
    endtask

    initial begin
        int  waited;
        bit  sready;
        forever begin
            @(posedge clk_i or negedge reset_n_i);
            if (!reset_n_i) begin
                m_init = 1'b1;
                g      = -1;
                m_rst  = 3'b111;
                m_done = 1'b0;
                m_err  = 1'b0;
                m_idx  = 0;
            end else begin
                g++;
                if (g < 4096) hist[g] = ready_i;
                if (m_init || soft_reset_i) begin
                    if (m_init) hist_lo = g;
                    m_init = 1'b0;
                    start  = g;
                    wstart = g + P + H;
                    m_idx  = 0;
                    m_rst  = 3'b111;
                    m_done = 1'b0;
                    m_err  = 1'b0;
                end else if (!m_done && !m_err && g > wstart) begin
                    // ready seen by the sequencer at edge g was sampled at edge g-2
                    waited = g - wstart;
                    sready = (g - 2 >= hist_lo) && hist[g-2][m_idx];
                    if (waited >= S && sready) begin
                        m_rst[m_idx] = 1'b0;
                        if (m_idx == N - 1) m_done = 1'b1;
                        else m_idx++;
                        wstart = g;
                    end else if (waited == T - 1) begin
                        m_err = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        bp_reset_seq_state_e es;
        int d;
        bit epll;
        forever begin
            @(negedge clk_i);
            if (reset_n_i) begin
                if (m_init) begin
                    es   = e_init;
                    epll = 1'b0;
                end else begin
                    d    = g - start;
                    epll = (d < P);
                    if (d < P)          es = e_pulse;
                    else if (d < P + H) es = e_hold;
                    else if (m_err)     es = e_error;
                    else if (m_done)    es = e_run;
                    else                es = e_wait;
                end
                chk("pll_reset_o", pll_reset_o, epll);
                chk("reset_o", reset_o, m_rst);
                chk("done_o", done_o, m_done);
                chk("error_o", error_o, m_err);
                chk("state_o", state_o, es);
                if (es == e_wait || es == e_error) chk("domain_idx_o", domain_idx_o, m_idx);
            end
        end
    end

    task automatic goto_edge(input int e);
        int guard = 0;
        while (g < e) begin
            @(posedge clk_i);
            #1;
            guard++;
            if (guard > 5000) begin
                vectors++;
                miscompares++;
                $display("FAIL goto_edge: edge %0d not reached, at %0d", e, g);
                break;
            end
        end
    endtask

    task automatic restart(input logic [2:0] rdy);
        reset_n_i = 1'b0;
        ready_i   = rdy;
        @(posedge clk_i);
        @(posedge clk_i);
        #1 reset_n_i = 1'b1;
    endtask

    initial begin
        // All ready high
        restart(3'b111);
        #1;
        chk("rst_state", state_o, e_init);
        chk("rst_reset", reset_o, 3'b111);
        chk("rst_pll", pll_reset_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_err", error_o, 1'b0);
        chk("rst_idx", domain_idx_o, 2'd0);
        goto_edge(0);  chk("pulse_first", pll_reset_o, 1'b1);
        goto_edge(3);  chk("pulse_last", pll_reset_o, 1'b1);
        goto_edge(4);  chk("pulse_end", pll_reset_o, 1'b0);
        chk("hold_state", state_o, e_hold);
        goto_edge(20); chk("wait_state", state_o, e_wait);
        goto_edge(27); chk("d0_held", reset_o, 3'b111);
        goto_edge(28); chk("d0_rel", reset_o, 3'b110);
        goto_edge(36); chk("d1_rel", reset_o, 3'b100);
        goto_edge(43); chk("done_early", done_o, 1'b0);
        goto_edge(44); chk("d2_rel", reset_o, 3'b000);
        chk("done_set", done_o, 1'b1);
        chk("run_state", state_o, e_run);
        // Ready loss after release is ignored
        goto_edge(100); ready_i = 3'b000;
        goto_edge(150); chk("ready_drop", reset_o, 3'b000);
        ready_i = 3'b111;
        // Soft reset from run
        goto_edge(199); soft_reset_i = 1'b1;
        goto_edge(200); soft_reset_i = 1'b0;
        chk("soft_reset_o", reset_o, 3'b111);
        chk("soft_done", done_o, 1'b0);
        chk("soft_pll", pll_reset_o, 1'b1);
        goto_edge(203); chk("soft_pll_last", pll_reset_o, 1'b1);
        goto_edge(204); chk("soft_pll_end", pll_reset_o, 1'b0);
        goto_edge(243); chk("soft_done_early", done_o, 1'b0);
        goto_edge(244); chk("soft_done_set", done_o, 1'b1);
        // Soft reset coinciding with domain 0 release
        goto_edge(299); soft_reset_i = 1'b1;
        goto_edge(300); soft_reset_i = 1'b0;
        goto_edge(327); soft_reset_i = 1'b1;
        goto_edge(328); soft_reset_i = 1'b0;
        chk("prio_reset", reset_o, 3'b111);
        chk("prio_state", state_o, e_pulse);
        goto_edge(355); chk("prio_held", reset_o, 3'b111);
        goto_edge(356); chk("prio_rel", reset_o, 3'b110);
        // Asynchronous reset during wait
        goto_edge(366);
        #2 reset_n_i = 1'b0;
        #1;
        chk("async_reset", reset_o, 3'b111);
        chk("async_state", state_o, e_init);
        chk("async_idx", domain_idx_o, 2'd0);
        chk("async_pll", pll_reset_o, 1'b0);
        // Late ready on domain 1
        restart(3'b101);
        goto_edge(28);  chk("late_d0", reset_o, 3'b110);
        goto_edge(99);  ready_i = 3'b111;
        goto_edge(101); chk("late_held", reset_o, 3'b110);
        chk("late_idx", domain_idx_o, 2'd1);
        goto_edge(102); chk("late_rel", reset_o, 3'b100);
        goto_edge(109); chk("late_d2_held", reset_o, 3'b100);
        goto_edge(110); chk("late_d2_rel", reset_o, 3'b000);
        chk("late_done", done_o, 1'b1);
        // Timeout on domain 1
        restart(3'b101);
        goto_edge(1050); chk("to_err_early", error_o, 1'b0);
        goto_edge(1051); chk("to_err", error_o, 1'b1);
        chk("to_reset", reset_o, 3'b110);
        chk("to_state", state_o, e_error);
        goto_edge(1080); chk("to_sticky", error_o, 1'b1);
        goto_edge(1099); soft_reset_i = 1'b1;
        goto_edge(1100); soft_reset_i = 1'b0;
        chk("to_soft_err", error_o, 1'b0);
        chk("to_soft_state", state_o, e_pulse);
        goto_edge(1130);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
